ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Single-port RAM arbiter sitting between the instruction-fetch and data-access request ports of the cache level and the cpu_ram_if RAM port.
- Serialises requests onto one RAM transaction at a time.
- Data has priority; a streak counter prevents fetch starvation.
- A watchdog aborts transactions that never complete and reports the abort on err.

Parameters:
- MAX_D_STREAK, 4: consecutive data grants allowed while a fetch is pending before the fetch is forced; must be at least 1.
- TIMEOUT, 64: maximum grant-state cycles without ramstate ACCESS/ERROR before the transaction is aborted.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- iREN  in  1  fetch read request; held until iwait is low.
- iaddr  in  32  fetch address.
- iwait  out  1  fetch stall; low for exactly the completing cycle.
- iload  out  32  fetch data; valid when iwait is low.
- dREN  in  1  data read request.
- dWEN  in  1  data write request; wins over dREN if both are high.
- daddr  in  32  data address.
- dstore  in  32  write data.
- dwait  out  1  data stall; low for exactly the completing cycle.
- dload  out  32  read data; valid when dwait is low.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramload  in  32  RAM read data.
- ramstate  in  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR.
- err  out  1  one-cycle pulse on a RAM ERROR or watchdog abort.

Behaviour:
- Reset (RST high at an edge): state IDLE, streak = 0, watchdog = 0. Reset overrides any in-flight transaction; no completion is signalled.
- Output values in reset and in IDLE: iwait = 1, dwait = 1, iload = 0, dload = 0, ram* = 0, err = 0.
- States: IDLE, GNT_D, GNT_I.
- IDLE arbitration, evaluated at each edge:
  - dreq (dREN | dWEN) and iREN both high, streak < MAX_D_STREAK: go to GNT_D.
  - Both high, streak = MAX_D_STREAK: go to GNT_I.
  - Only one request high: grant it.
  - Neither high: stay in IDLE.
- Grant-state outputs: combinational mux of the granted requester onto ramaddr, ramstore, ramREN and ramWEN.
  - In GNT_D with dWEN high: ramWEN = 1 and ramREN = 0.
  - In GNT_I: ramWEN = 0 and ramstore = 0.
- Completion happens in a grant-state cycle where ramstate = ACCESS:
  - Granted wait goes low combinationally in that cycle.
  - Granted load = ramload; the other load stays 0.
  - Next state is IDLE.
  - Consequence: every transaction has at least one IDLE bubble, so minimum latency is request edge to completing cycle = 1 cycle when RAM returns ACCESS immediately.
- RAM error (ramstate = ERROR in a grant state): wait goes low, load = 0, err = 1 in that cycle, next state IDLE.
- Watchdog:
  - Increments every grant-state cycle; cleared in IDLE.
  - Abort cycle is the cycle in which watchdog = TIMEOUT-1 and ramstate is neither ACCESS nor ERROR.
  - In the abort cycle: wait low, load = 0, err = 1, next state IDLE.
- Request withdrawn mid-grant (the granted requester's enables drop):
  - RAM enables drop combinationally in the same cycle.
  - No completion and no err.
  - Next state IDLE.
- Streak counter, updated at a completing or error edge:
  - GNT_D completion with iREN high: increment, saturating at MAX_D_STREAK.
  - GNT_D completion with iREN low: clear.
  - GNT_I completion: clear.
  - Watchdog abort and withdrawal: streak unchanged.
- Address, data and enable changes by the granted requester during a grant pass straight through to the RAM port; the arbiter does not latch them.
- The non-granted requester always sees wait = 1 and load = 0.

Test Plan:
- Reset: RST high for 2 cycles with both requests active -> iwait = dwait = 1, ram* = 0, err = 0; first grant occurs after RST falls.
- Fetch only, with ramstate = ACCESS on the 3rd grant cycle and ramload = 0xDEADBEEF -> iwait low for exactly 1 cycle with iload = 0xDEADBEEF, then one IDLE cycle.
- Simultaneous dWEN (daddr = 0x100, dstore = 0x55) and iREN, RAM instant -> data write first (ramWEN = 1, ramaddr = 0x100), fetch granted next.
- MAX_D_STREAK = 2, dREN and iREN held continuously -> grant order D, D, I, D, D, I.
- ramstate stuck at BUSY with TIMEOUT = 8 -> dwait low and err = 1 on the 8th grant cycle; a pending fetch is granted afterwards.
- ramstate = ERROR on the 2nd cycle of GNT_I -> iwait low, iload = 0, err pulse of 1 cycle. Separately, dREN dropped mid-grant -> ramREN = 0 in the same cycle, no err.

Source files
------------

// File: rtl/ram_arbiter.sv
// Single-port RAM arbiter between the fetch and data ports of the cache level.
// Data has priority; a streak counter bounds fetch starvation and a watchdog aborts hung transfers.
module ram_arbiter #(
  parameter int unsigned MAX_D_STREAK = 4,
  parameter int unsigned TIMEOUT      = 64
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  output logic        ramREN,
  output logic        ramWEN,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        err
);

  localparam int unsigned ST_W = $clog2(MAX_D_STREAK + 1);
  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
  localparam logic [1:0]  RS_ACCESS = 2'd2;
  localparam logic [1:0]  RS_ERROR  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_D = 2'd1,
    GNT_I = 2'd2
  } state_t;

  state_t          state;
  logic [ST_W-1:0] streak;
  logic [WD_W-1:0] wd;

  logic dreq;
  logic owner_req;
  logic at_limit;
  logic done_ok;
  logic done_err;
  logic abort;
  logic finish;
  logic withdrawn;

  // Outcome of the current grant cycle
  always_comb begin
    dreq      = dREN | dWEN;
    owner_req = 1'b0;
    case (state)
      GNT_D:   owner_req = dreq;
      GNT_I:   owner_req = iREN;
      default: owner_req = 1'b0;
    endcase
    at_limit  = (wd == WD_W'(TIMEOUT - 1));
    done_ok   = owner_req && (ramstate == RS_ACCESS);
    done_err  = owner_req && (ramstate == RS_ERROR);
    abort     = owner_req && !done_ok && !done_err && at_limit;
    finish    = done_ok || done_err || abort;
    withdrawn = (state != IDLE) && !owner_req;
  end

  // RAM port mux and requester responses
  always_comb begin
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = 32'h0;
    dload    = 32'h0;
    ramaddr  = 32'h0;
    ramstore = 32'h0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    err      = done_err || abort;
    case (state)
      GNT_D: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN && !dWEN;
        dwait    = !finish;
        if (done_ok) dload = ramload;
      end
      GNT_I: begin
        ramaddr = iaddr;
        ramREN  = iREN;
        iwait   = !finish;
        if (done_ok) iload = ramload;
      end
      default: ;
    endcase
  end

  // Arbitration, streak and watchdog
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      streak <= '0;
      wd     <= '0;
    end else begin
      case (state)
        IDLE: begin
          wd <= '0;
          if (dreq && (!iREN || (streak < ST_W'(MAX_D_STREAK)))) state <= GNT_D;
          else if (iREN) state <= GNT_I;
        end
        GNT_D, GNT_I: begin
          if (finish || withdrawn) begin
            state <= IDLE;
            wd    <= '0;
            if (done_ok || done_err) begin
              if (state == GNT_I || !iREN) streak <= '0;
              else if (streak != ST_W'(MAX_D_STREAK)) streak <= streak + ST_W'(1);
            end
          end else begin
            wd <= wd + WD_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed vector table, hand sequences for
// streak/timeout/error/withdrawal, then randomized traffic against a transaction-level model.
module tb_ram_arbiter;

  localparam int unsigned MAXS = 2;
  localparam int unsigned TMO  = 8;
  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACC = 2'd2, ERR = 2'd3;
  localparam logic [31:0] IA = 32'h40, DA = 32'h100, DS = 32'h55;

  logic        CLK, RST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic        iwait, dwait, ramREN, ramWEN, err;
  logic [31:0] iload, dload, ramaddr, ramstore;

  int checks = 0;
  int errors = 0;

  ram_arbiter #(.MAX_D_STREAK(MAXS), .TIMEOUT(TMO)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramaddr(ramaddr), .ramstore(ramstore), .ramREN(ramREN), .ramWEN(ramWEN),
    .ramload(ramload), .ramstate(ramstate), .err(err)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic        rst, iren, dren, dwen;
    logic [31:0] ia, da, ds, rl;
    logic [1:0]  rs;
    logic [132:0] e;
  } vec_t;

  function automatic logic [132:0] pk(input logic iw, dw, er, rr, rw,
                                      input logic [31:0] il, dl, ra, rst_o);
    return {iw, dw, er, rr, rw, il, dl, ra, rst_o};
  endfunction

  function automatic logic [132:0] outs();
    return {iwait, dwait, err, ramREN, ramWEN, iload, dload, ramaddr, ramstore};
  endfunction

  function automatic vec_t mkv(input logic rst, iren, dren, dwen,
                               input logic [31:0] ia, da, ds, rl, input logic [1:0] rs,
                               input logic [132:0] e);
    vec_t v;
    v.rst = rst; v.iren = iren; v.dren = dren; v.dwen = dwen;
    v.ia = ia; v.da = da; v.ds = ds; v.rl = rl; v.rs = rs; v.e = e;
    return v;
  endfunction

  task automatic chk(input string name, input logic [132:0] act, input logic [132:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  task automatic drive(input logic rst, iren, dren, dwen, input logic [31:0] ia, da, ds, rl,
                       input logic [1:0] rs);
    RST = rst; iREN = iren; dREN = dren; dWEN = dwen;
    iaddr = ia; daddr = da; dstore = ds; ramload = rl; ramstate = rs;
  endtask

  // Reference model: who holds the RAM, how long it has held it, and the data streak
  int m_owner, m_age, m_streak;

  vec_t tbl [9];
  logic [132:0] idle_o;
  int got [$];
  int exp_ord [6];

  initial begin
    idle_o = pk(1, 1, 0, 0, 0, 0, 0, 0, 0);
    exp_ord = '{1, 1, 2, 1, 1, 2};
    tbl[0] = mkv(1, 1, 0, 1, IA, DA, DS, 32'h0, FREE, idle_o);
    tbl[1] = mkv(1, 1, 0, 1, IA, DA, DS, 32'h0, FREE, idle_o);
    tbl[2] = mkv(0, 1, 0, 1, IA, DA, DS, 32'h0, FREE, idle_o);
    tbl[3] = mkv(0, 1, 0, 1, IA, DA, DS, 32'h0, ACC, pk(1, 0, 0, 0, 1, 0, 0, DA, DS));
    tbl[4] = mkv(0, 1, 0, 0, IA, DA, DS, 32'h0, FREE, idle_o);
    tbl[5] = mkv(0, 1, 0, 0, IA, DA, DS, 32'h0, BUSY, pk(1, 1, 0, 1, 0, 0, 0, IA, 0));
    tbl[6] = mkv(0, 1, 0, 0, IA, DA, DS, 32'h0, BUSY, pk(1, 1, 0, 1, 0, 0, 0, IA, 0));
    tbl[7] = mkv(0, 1, 0, 0, IA, DA, DS, 32'hDEADBEEF, ACC,
                 pk(0, 1, 0, 1, 0, 32'hDEADBEEF, 0, IA, 0));
    tbl[8] = mkv(0, 0, 0, 0, IA, DA, DS, 32'hDEADBEEF, FREE, idle_o);

    drive(1, 1, 0, 1, IA, DA, DS, 32'h0, FREE);
    for (int i = 0; i < 9; i++) begin
      @(negedge CLK);
      drive(tbl[i].rst, tbl[i].iren, tbl[i].dren, tbl[i].dwen,
            tbl[i].ia, tbl[i].da, tbl[i].ds, tbl[i].rl, tbl[i].rs);
      #1 chk($sformatf("vec%0d", i), outs(), tbl[i].e);
    end

    // Streak: data and fetch held, RAM instant
    for (int c = 0; c < 40 && got.size() < 6; c++) begin
      @(negedge CLK);
      drive(0, 1, 1, 0, IA, DA, DS, $urandom, ACC);
      #1;
      if (!dwait) got.push_back(1);
      if (!iwait) got.push_back(2);
    end
    chk("streak_count", 133'(got.size()), 133'(6));
    for (int i = 0; i < 6 && i < got.size(); i++)
      chk($sformatf("streak_ord%0d", i), 133'(got[i]), 133'(exp_ord[i]));

    // Watchdog abort on a data read with a fetch pending
    @(negedge CLK);
    drive(0, 1, 1, 0, IA, DA, DS, 32'h1111, BUSY);
    for (int k = 1; k <= int'(TMO); k++) begin
      @(negedge CLK);
      #1 chk($sformatf("tmo_k%0d", k), 133'({dwait, err, ramREN, dload}),
             133'({(k < int'(TMO)), (k == int'(TMO)), 1'b1, 32'h0}));
    end
    @(negedge CLK);
    drive(0, 1, 0, 0, IA, DA, DS, 32'h1111, BUSY);
    #1 chk("tmo_idle", outs(), idle_o);
    @(negedge CLK);
    drive(0, 1, 0, 0, IA, DA, DS, 32'hCAFE0001, ACC);
    #1 chk("tmo_fetch", outs(), pk(0, 1, 0, 1, 0, 32'hCAFE0001, 0, IA, 0));

    // RAM error on second fetch grant cycle
    @(negedge CLK);
    drive(0, 1, 0, 0, IA, DA, DS, 32'h0, BUSY);
    @(negedge CLK);
    #1 chk("err_c1", 133'({iwait, err}), 133'(2'b10));
    @(negedge CLK);
    drive(0, 1, 0, 0, IA, DA, DS, 32'h13579BDF, ERR);
    #1 chk("err_c2", outs(), pk(0, 1, 1, 1, 0, 0, 0, IA, 0));
    @(negedge CLK);
    drive(0, 0, 0, 0, IA, DA, DS, 32'h0, FREE);
    #1 chk("err_after", outs(), idle_o);

    // Data read withdrawn mid-grant
    @(negedge CLK);
    drive(0, 0, 1, 0, IA, 32'h200, DS, 32'h0, BUSY);
    @(negedge CLK);
    #1 chk("wd_gnt", outs(), pk(1, 1, 0, 1, 0, 0, 0, 32'h200, DS));
    @(negedge CLK);
    dREN = 1'b0;
    #1 chk("wd_drop", 133'({dwait, err, ramREN, ramWEN}), 133'(4'b1000));
    @(negedge CLK);
    #1 chk("wd_idle", outs(), idle_o);

    // Randomized traffic against the model
    @(negedge CLK);
    RST = 1'b1;
    m_owner = 0; m_age = 0; m_streak = 0;
    for (int n = 0; n < 3000; n++) begin
      logic        slow, dreq, active, e_iw, e_dw, e_er, e_rr, e_rw;
      logic [31:0] e_il, e_dl, e_ra, e_rs;
      int          outcome, r;
      @(negedge CLK);
      slow = ((n / 250) % 2) == 1;
      RST = ($urandom_range(0, 99) == 0);
      iaddr = $urandom; daddr = $urandom; dstore = $urandom; ramload = $urandom;
      r = int'($urandom_range(0, 29));
      if (slow) begin
        iREN = 1'b1;
        if ($urandom_range(0, 19) == 0) begin
          dREN = 1'($urandom_range(0, 1));
          dWEN = ($urandom_range(0, 3) == 0);
        end
        ramstate = (r == 0) ? ACC : (r == 1) ? ERR : (r < 16) ? BUSY : FREE;
      end else begin
        iREN = ($urandom_range(0, 3) != 0);
        dREN = 1'($urandom_range(0, 1));
        dWEN = ($urandom_range(0, 3) == 0);
        ramstate = (r < 10) ? BUSY : (r < 13) ? FREE : (r < 27) ? ACC : ERR;
      end
      #1;
      dreq = dREN || dWEN;
      e_iw = 1; e_dw = 1; e_er = 0; e_rr = 0; e_rw = 0;
      e_il = 0; e_dl = 0; e_ra = 0; e_rs = 0;
      active = 0;
      if (m_owner == 1) begin
        e_ra = daddr; e_rs = dstore; e_rw = dWEN; e_rr = dREN && !dWEN; active = dreq;
      end else if (m_owner == 2) begin
        e_ra = iaddr; e_rr = iREN; active = iREN;
      end
      outcome = 0;
      if (m_owner != 0) begin
        if (!active) outcome = 4;
        else if (ramstate == ACC) outcome = 1;
        else if (ramstate == ERR) outcome = 2;
        else if (m_age == int'(TMO) - 1) outcome = 3;
      end
      if (outcome >= 1 && outcome <= 3) begin
        if (m_owner == 1) begin
          e_dw = 0;
          if (outcome == 1) e_dl = ramload;
        end else begin
          e_iw = 0;
          if (outcome == 1) e_il = ramload;
        end
        e_er = (outcome != 1);
      end
      chk($sformatf("rand%0d", n), outs(), pk(e_iw, e_dw, e_er, e_rr, e_rw, e_il, e_dl, e_ra, e_rs));
      if (RST) begin
        m_owner = 0; m_age = 0; m_streak = 0;
      end else if (m_owner == 0) begin
        m_age = 0;
        if (dreq && iREN) m_owner = (m_streak < int'(MAXS)) ? 1 : 2;
        else if (dreq) m_owner = 1;
        else if (iREN) m_owner = 2;
      end else if (outcome != 0) begin
        if (outcome <= 2) begin
          if (m_owner == 1 && iREN) m_streak = (m_streak + 1 > int'(MAXS)) ? int'(MAXS) : m_streak + 1;
          else m_streak = 0;
        end
        m_owner = 0; m_age = 0;
      end else begin
        m_age++;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
